target_bbox_extractor: RTL and testbench

- Produces the per-frame target bounding box (x_min, x_max, y_min, y_max) and the tracking-enable flag consumed by the pan/tilt stepper controller.
- Scans the binary target-mask pixel stream from the camera/threshold pipeline and accumulates the box extents over each frame.
- Commits the box once per frame at the next frame sync. Holds the last valid box when the target is absent, and flags loss after a programmable run of empty frames.

---
 rtl/target_bbox_extractor.sv | 153 +++++++++++++++
 tb/tb_target_bbox_extractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/target_bbox_extractor.sv
// Per-frame bounding box of a binary target mask, committed at each frame sync,
// with a held box and a loss flag after a run of empty frames.
module target_bbox_extractor #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int MIN_PIXELS  = 64,
  parameter int LOST_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        de,
  input  logic        mask,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic        frame_done,
  output logic        target_lost
);

  localparam logic [0:0] WAIT_SYNC = 1'b0;
  localparam logic [0:0] ACCUM     = 1'b1;

  localparam int          EW       = (LOST_FRAMES < 2) ? 1 : $clog2(LOST_FRAMES + 1);
  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [20:0] PIX_MIN  = 21'(MIN_PIXELS);
  localparam logic [EW-1:0] LOST_LIM = EW'(LOST_FRAMES);
  localparam logic [10:0] X_CENTRE = 11'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_CENTRE = 10'(V_ACTIVE / 2);

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc_sat10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  function automatic logic [20:0] inc_sat21(input logic [20:0] v);
    return (&v) ? v : v + 21'd1;
  endfunction

  function automatic logic [EW-1:0] inc_sat_lost(input logic [EW-1:0] v);
    return (v >= LOST_LIM) ? LOST_LIM : v + EW'(1);
  endfunction

  logic [0:0]    state;
  logic          vs_d, de_d;
  logic [10:0]   x_cnt;
  logic [9:0]    y_cnt;
  logic [10:0]   acc_xmin, acc_xmax;
  logic [9:0]    acc_ymin, acc_ymax;
  logic [20:0]   pix_cnt;
  logic [EW-1:0] empty_cnt;

  logic          vs_rise, de_fall, pix_hit;
  logic [9:0]    pix_y;
  logic [10:0]   base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [9:0]    base_ymin, base_ymax, nxt_ymin, nxt_ymax;
  logic [20:0]   base_cnt, nxt_cnt;
  logic [EW-1:0] empty_inc;

  // A pixel coincident with the frame sync is the first sample of the new frame.
  always_comb begin
    vs_rise   = vs & ~vs_d;
    de_fall   = ~de & de_d;
    pix_y     = vs_rise ? 10'd0 : y_cnt;
    pix_hit   = de & mask & (x_cnt < H_LIM) & (pix_y < V_LIM) &
                ((state == ACCUM) | vs_rise);
    base_xmin = vs_rise ? 11'h7FF : acc_xmin;
    base_xmax = vs_rise ? 11'h000 : acc_xmax;
    base_ymin = vs_rise ? 10'h3FF : acc_ymin;
    base_ymax = vs_rise ? 10'h000 : acc_ymax;
    base_cnt  = vs_rise ? 21'd0   : pix_cnt;
    nxt_xmin  = base_xmin;
    nxt_xmax  = base_xmax;
    nxt_ymin  = base_ymin;
    nxt_ymax  = base_ymax;
    nxt_cnt   = base_cnt;
    if (pix_hit) begin
      if (x_cnt < base_xmin) nxt_xmin = x_cnt;
      if (x_cnt > base_xmax) nxt_xmax = x_cnt;
      if (pix_y < base_ymin) nxt_ymin = pix_y;
      if (pix_y > base_ymax) nxt_ymax = pix_y;
      nxt_cnt = inc_sat21(base_cnt);
    end
    empty_inc = inc_sat_lost(empty_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_SYNC;
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      x_cnt       <= 11'd0;
      y_cnt       <= 10'd0;
      acc_xmin    <= 11'h7FF;
      acc_xmax    <= 11'h000;
      acc_ymin    <= 10'h3FF;
      acc_ymax    <= 10'h000;
      pix_cnt     <= 21'd0;
      empty_cnt   <= '0;
      x_min       <= X_CENTRE;
      x_max       <= X_CENTRE;
      y_min       <= Y_CENTRE;
      y_max       <= Y_CENTRE;
      frame_done  <= 1'b0;
      target_lost <= 1'b1;
    end else begin
      vs_d       <= vs;
      de_d       <= de;
      frame_done <= 1'b0;

      if (de_fall)  x_cnt <= 11'd0;
      else if (de)  x_cnt <= inc_sat11(x_cnt);

      if (vs_rise)      y_cnt <= 10'd0;
      else if (de_fall) y_cnt <= inc_sat10(y_cnt);

      acc_xmin <= nxt_xmin;
      acc_xmax <= nxt_xmax;
      acc_ymin <= nxt_ymin;
      acc_ymax <= nxt_ymax;
      pix_cnt  <= nxt_cnt;

      case (state)
        WAIT_SYNC: begin
          if (vs_rise) state <= ACCUM;
        end
        default: begin
          // Commit uses the accumulators as they stood before this cycle's pixel.
          if (vs_rise) begin
            frame_done <= 1'b1;
            if (pix_cnt >= PIX_MIN) begin
              x_min       <= acc_xmin;
              x_max       <= acc_xmax;
              y_min       <= acc_ymin;
              y_max       <= acc_ymax;
              empty_cnt   <= '0;
              target_lost <= 1'b0;
            end else begin
              empty_cnt <= empty_inc;
              if (empty_inc == LOST_LIM) target_lost <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_bbox_extractor.sv
// Directed and randomized frames against a frame-level bounding-box model.
module tb_target_bbox_extractor;

  localparam int H     = 32;
  localparam int V     = 16;
  localparam int MINP  = 4;
  localparam int LOSTF = 3;
  localparam int ROWS  = 18;
  localparam int COLS  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0, de = 1'b0, mask = 1'b0;
  logic [10:0] x_min, x_max;
  logic [9:0]  y_min, y_max;
  logic        frame_done, target_lost;

  target_bbox_extractor #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP), .LOST_FRAMES(LOSTF)
  ) dut (
    .clk(clk), .rst(rst), .vs(vs), .de(de), .mask(mask),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .frame_done(frame_done), .target_lost(target_lost)
  );

  always #5 clk = ~clk;

  bit img [0:ROWS-1][0:COLS-1];
  int p_cnt, p_xmin, p_xmax, p_ymin, p_ymax;
  int e_xmin, e_xmax, e_ymin, e_ymax, e_lost, e_empty;
  bit started;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input bit v, input bit d, input bit m);
    vs = v; de = d; mask = m;
    @(posedge clk); #1;
  endtask

  task automatic check_outputs(input string tag, input int fd);
    check({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    check({tag, ".x_min"}, 32'(x_min), 32'(e_xmin));
    check({tag, ".x_max"}, 32'(x_max), 32'(e_xmax));
    check({tag, ".y_min"}, 32'(y_min), 32'(e_ymin));
    check({tag, ".y_max"}, 32'(y_max), 32'(e_ymax));
    check({tag, ".target_lost"}, 32'(target_lost), 32'(e_lost));
  endtask

  task automatic clear_pending();
    p_cnt = 0; p_xmin = 2047; p_xmax = 0; p_ymin = 1023; p_ymax = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; vs = 1'b0; de = 1'b0; mask = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    e_xmin = H / 2; e_xmax = H / 2; e_ymin = V / 2; e_ymax = V / 2;
    e_lost = 1; e_empty = 0; started = 1'b0;
    clear_pending();
    check_outputs("reset", 0);
  endtask

  // Model of one frame sync: first sync after reset only arms, later ones commit.
  task automatic commit_check(input string tag);
    int fd;
    if (!started) begin
      fd = 0;
      started = 1'b1;
    end else begin
      fd = 1;
      if (p_cnt >= MINP) begin
        e_xmin = p_xmin; e_xmax = p_xmax; e_ymin = p_ymin; e_ymax = p_ymax;
        e_empty = 0; e_lost = 0;
      end else begin
        if (e_empty < LOSTF) e_empty++;
        if (e_empty == LOSTF) e_lost = 1;
      end
    end
    check_outputs(tag, fd);
    clear_pending();
  endtask

  task automatic vsync(input string tag);
    pix(1, 0, 0);
    commit_check(tag);
    pix(1, 0, 0);
    check({tag, ".fd_one_cycle"}, 32'(frame_done), 32'd0);
    pix(0, 0, 0);
    pix(0, 0, 0);
  endtask

  task automatic clear_img();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) img[r][c] = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int r = y0; r <= y1; r++)
      for (int c = x0; c <= x1; c++) img[r][c] = 1'b1;
  endtask

  task automatic frame_stats(input int nrows, input int linew, output int cnt,
                             output int xmn, output int xmx, output int ymn, output int ymx);
    cnt = 0; xmn = 2047; xmx = 0; ymn = 1023; ymx = 0;
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < linew; c++)
        if (img[r][c] && r < V && c < H) begin
          cnt++;
          if (c < xmn) xmn = c;
          if (c > xmx) xmx = c;
          if (r < ymn) ymn = r;
          if (r > ymx) ymx = r;
        end
  endtask

  // With coinc set, the sync rises on the first pixel of row 0 and commits the previous frame.
  task automatic drive_frame(input string tag, input int nrows, input int linew, input bit coinc);
    int cnt, xmn, xmx, ymn, ymx;
    frame_stats(nrows, linew, cnt, xmn, xmx, ymn, ymx);
    if (!coinc) begin
      p_cnt = cnt; p_xmin = xmn; p_xmax = xmx; p_ymin = ymn; p_ymax = ymx;
    end
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < linew; c++) begin
        if (coinc && r == 0 && c == 0) begin
          pix(1, 1, img[0][0]);
          commit_check({tag, ".coinc"});
          p_cnt = cnt; p_xmin = xmn; p_xmax = xmx; p_ymin = ymn; p_ymax = ymx;
        end else begin
          pix(0, 1, img[r][c]);
          if (coinc && r == 0 && c == 1)
            check({tag, ".coinc_fd_one_cycle"}, 32'(frame_done), 32'd0);
        end
      end
      pix(0, 0, 0);
      pix(0, 0, 0);
    end
  endtask

  initial begin
    int nrows, linew, nset;
    bit coinc;

    do_reset(3);

    clear_img(); set_rect(2, 4, 1, 2);
    drive_frame("pre_sync", 4, 32, 0);
    vsync("first_sync");

    clear_img(); set_rect(5, 9, 3, 6);
    drive_frame("box_a", 8, 32, 0);
    vsync("commit_a");

    clear_img(); set_rect(1, 3, 0, 0);
    drive_frame("sparse1", 2, 32, 0);
    vsync("commit_sparse1");
    clear_img(); set_rect(10, 10, 2, 4);
    drive_frame("sparse2", 6, 32, 0);
    vsync("commit_sparse2");
    vsync("commit_empty");

    clear_img(); set_rect(20, 21, 10, 11);
    drive_frame("box_b", 12, 32, 0);
    vsync("commit_b");

    clear_img(); set_rect(33, 39, 2, 2);
    drive_frame("long_de", 3, 40, 0);
    vsync("commit_long_de");

    clear_img(); set_rect(0, 3, 0, 1);
    drive_frame("origin", 2, 32, 1);
    vsync("commit_origin");

    clear_img(); set_rect(4, 8, 0, 1);
    drive_frame("mid_frame", 2, 32, 0);
    do_reset(1);
    vsync("sync_after_reset");
    clear_img(); set_rect(6, 7, 4, 5);
    drive_frame("post_reset", 6, 32, 0);
    vsync("commit_post_reset");

    for (int k = 0; k < 16; k++) begin
      clear_img();
      nrows = $urandom_range(1, ROWS);
      linew = $urandom_range(8, COLS);
      nset  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 40);
      for (int i = 0; i < nset; i++)
        img[$urandom_range(0, nrows - 1)][$urandom_range(0, linew - 1)] = 1'b1;
      coinc = 1'($urandom_range(0, 1));
      if (!coinc) vsync("rand_sync");
      drive_frame("rand", nrows, linew, coinc);
    end
    vsync("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
